// File: rtl/shift_register_4b.sv
// WIDTH-bit shift/rotate/load register with a serial output bit, a saturating
// operation counter and a one-cycle done pulse when the counter first reaches WIDTH.
module shift_register_4b #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic             dir,
  input  logic             s_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             s_out,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [1:0] MODO_SHIFT  = 2'b00;
  localparam logic [1:0] MODO_ROTATE = 2'b01;
  localparam logic [1:0] MODO_LOAD   = 2'b10;

  logic [WIDTH-1:0] q_nxt;
  logic             s_out_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             done_nxt;
  logic             moving;
  logic             fill_bit;

  // Shift feeds s_in into the vacated end; rotate feeds back the bit leaving.
  always_comb begin
    fill_bit = s_in;
    if (modo == MODO_ROTATE) begin
      fill_bit = dir ? q[0] : q[WIDTH-1];
    end
  end

  always_comb begin
    q_nxt     = q;
    s_out_nxt = s_out;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    moving    = 1'b0;
    if (!enb) begin
      case (modo)
        MODO_SHIFT, MODO_ROTATE: begin
          moving = 1'b1;
          if (dir) begin
            q_nxt     = {fill_bit, q[WIDTH-1:1]};
            s_out_nxt = q[0];
          end else begin
            q_nxt     = {q[WIDTH-2:0], fill_bit};
            s_out_nxt = q[WIDTH-1];
          end
        end
        MODO_LOAD: begin
          q_nxt     = d;
          s_out_nxt = 1'b0;
          cnt_nxt   = '0;
        end
        default: ;
      endcase
    end
    // Counter saturates at WIDTH; done fires only on the WIDTH-1 -> WIDTH step.
    if (moving && (cnt < CW'(WIDTH))) begin
      cnt_nxt  = cnt + CW'(1);
      done_nxt = (cnt == CW'(WIDTH - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      s_out <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      q     <= q_nxt;
      s_out <= s_out_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_shift_register_4b.sv
// Bench for shift_register_4b: directed scenarios followed by random traffic,
// every edge compared against an arithmetic reference model.
module tb_shift_register_4b;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             enb;
  logic [1:0]       modo;
  logic             dir;
  logic             s_in;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             s_out;
  logic [CW-1:0]    cnt;
  logic             done;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_q;
  int m_so;
  int m_cnt;
  int m_done;

  shift_register_4b #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .enb   (enb),
    .modo  (modo),
    .dir   (dir),
    .s_in  (s_in),
    .d     (d),
    .q     (q),
    .s_out (s_out),
    .cnt   (cnt),
    .done  (done)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input logic [1:0] m,
                            input logic dr, input logic si, input logic [WIDTH-1:0] dd);
    int out_bit;
    if (r) begin
      m_q = 0; m_so = 0; m_cnt = 0; m_done = 0;
    end else if (e) begin
      m_done = 0;
    end else if (m == 2'b10) begin
      m_q = int'(dd); m_so = 0; m_cnt = 0; m_done = 0;
    end else if (m == 2'b11) begin
      m_done = 0;
    end else begin
      if (dr) begin
        out_bit = m_q & 1;
        m_q = (m_q >> 1) | (((m == 2'b01) ? out_bit : int'(si)) << (WIDTH - 1));
      end else begin
        out_bit = (m_q >> (WIDTH - 1)) & 1;
        m_q = ((m_q << 1) | ((m == 2'b01) ? out_bit : int'(si))) & MASK;
      end
      m_so = out_bit;
      if (m_cnt < WIDTH) begin
        m_cnt++;
        m_done = (m_cnt == WIDTH) ? 1 : 0;
      end else begin
        m_done = 0;
      end
    end
  endtask

  // driver: apply inputs away from the edge, advance one edge, compare
  task automatic step(input string tag, input logic r, input logic e, input logic [1:0] m,
                      input logic dr, input logic si, input logic [WIDTH-1:0] dd);
    @(negedge clk);
    rst = r; enb = e; modo = m; dir = dr; s_in = si; d = dd;
    @(posedge clk);
    model_edge(r, e, m, dr, si, dd);
    #1;
    check({tag, ".q"},     32'(q),     32'(m_q));
    check({tag, ".s_out"}, 32'(s_out), 32'(m_so));
    check({tag, ".cnt"},   32'(cnt),   32'(m_cnt));
    check({tag, ".done"},  32'(done),  32'(m_done));
  endtask

  initial begin
    logic [3:0] so_exp;
    logic [3:0] rot_exp [4];
    rst = 1'b1; enb = 1'b0; modo = 2'b11; dir = 1'b0; s_in = 1'b0; d = '0;
    m_q = 0; m_so = 0; m_cnt = 0; m_done = 0;

    for (int i = 0; i < 3; i++) step("reset", 1, 0, 2'b00, 0, 1, 4'hF);
    check("reset.q_lit", 32'(q), 32'h0);

    // load then four shift-left edges
    step("load1011", 0, 0, 2'b10, 1, 1, 4'b1011);
    check("load1011.q_lit", 32'(q), 32'hB);
    so_exp = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      step("shl", 0, 0, 2'b00, 0, 0, 4'h0);
      check("shl.s_out_lit", 32'(s_out), 32'(so_exp[3-i]));
      check("shl.done_lit", 32'(done), (i == 3) ? 32'd1 : 32'd0);
    end
    check("shl.q_lit", 32'(q), 32'h0);
    check("shl.cnt_lit", 32'(cnt), 32'd4);

    // rotate right through a full cycle and one past saturation
    rot_exp[0] = 4'b1100; rot_exp[1] = 4'b0110; rot_exp[2] = 4'b0011; rot_exp[3] = 4'b1001;
    step("load1001", 0, 0, 2'b10, 0, 0, 4'b1001);
    for (int i = 0; i < 4; i++) begin
      step("ror", 0, 0, 2'b01, 1, 0, 4'h0);
      check("ror.q_lit", 32'(q), 32'(rot_exp[i]));
    end
    step("ror5", 0, 0, 2'b01, 1, 1, 4'h0);
    check("ror5.q_lit", 32'(q), 32'hC);
    check("ror5.cnt_lit", 32'(cnt), 32'd4);
    check("ror5.done_lit", 32'(done), 32'd0);

    // freeze and hold with cnt = 1
    step("load0011", 0, 0, 2'b10, 0, 0, 4'b0011);
    step("shl_to0110", 0, 0, 2'b00, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++) step("freeze", 0, 1, 2'b00, 0, 1, 4'hF);
    for (int i = 0; i < 3; i++) step("hold", 0, 0, 2'b11, 1, 1, 4'hF);
    check("hold.q_lit", 32'(q), 32'h6);
    check("hold.cnt_lit", 32'(cnt), 32'd1);

    // reset aborts a sequence even with enb high
    step("load1111", 0, 0, 2'b10, 0, 0, 4'b1111);
    step("shr", 0, 0, 2'b00, 1, 0, 4'h0);
    step("shr", 0, 0, 2'b00, 1, 0, 4'h0);
    step("abort", 1, 1, 2'b00, 0, 1, 4'h0);
    check("abort.cnt_lit", 32'(cnt), 32'd0);
    step("after_abort", 0, 0, 2'b11, 0, 0, 4'h0);
    check("after_abort.done_lit", 32'(done), 32'd0);

    // mixed directions, then load on the done cycle
    step("load1000", 0, 0, 2'b10, 0, 0, 4'b1000);
    for (int i = 0; i < 3; i++) step("mix_shl", 0, 0, 2'b00, 0, 1, 4'h0);
    check("mix_shl.q_lit", 32'(q), 32'h7);
    step("mix_shr", 0, 0, 2'b00, 1, 1, 4'h0);
    check("mix_shr.q_lit", 32'(q), 32'hB);
    check("mix_shr.done_lit", 32'(done), 32'd1);
    step("load_on_done", 0, 0, 2'b10, 0, 0, 4'b0101);
    check("load_on_done.done_lit", 32'(done), 32'd0);
    check("load_on_done.q_lit", 32'(q), 32'h5);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 4) == 0),
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_register_4b.md
SHIFT_REGISTER_4B -- requirements
Module: shift_register_4b

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits (legal values 2..16).
REQ-002 Port clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port enb  input  1  enable, LOW active; 1 = freeze all state.
REQ-005 Port modo  input  2  operation select: 00 shift, 01 rotate, 10 parallel load, 11 hold.
REQ-006 Port dir  input  1  direction for shift/rotate: 0 = left (toward MSB), 1 = right (toward LSB).
REQ-007 Port s_in  input  1  serial data in, used by shift only.
REQ-008 Port d  input  WIDTH  parallel load data.
REQ-009 Port q  output  WIDTH  register contents, registered.
REQ-010 Port s_out  output  1  last bit shifted or rotated out, registered.
REQ-011 Port cnt  output  ceil(log2(WIDTH+1))  shift/rotate operations since last load or reset, registered.
REQ-012 Port done  output  1  one-cycle pulse when cnt reaches WIDTH, registered.

Function
REQ-013 All outputs change only on rising clk edges; no combinational path from inputs to outputs.
REQ-014 Priority per edge: rst, then enb=1, then modo decode.
REQ-015 enb=1 (rst=0): q, s_out and cnt hold; done = 0.
REQ-016 Shift left (modo=00, dir=0): q <= {q[WIDTH-2:0], s_in}; s_out <= old q[WIDTH-1].
REQ-017 Shift right (modo=00, dir=1): q <= {s_in, q[WIDTH-1:1]}; s_out <= old q[0].
REQ-018 Rotate left (modo=01, dir=0): q <= {q[WIDTH-2:0], q[WIDTH-1]}; s_out <= old q[WIDTH-1].
REQ-019 Rotate right (modo=01, dir=1): q <= {q[0], q[WIDTH-1:1]}; s_out <= old q[0].
REQ-020 Load (modo=10): q <= d; s_out <= 0; cnt <= 0; done = 0; dir and s_in ignored.
REQ-021 Hold (modo=11): q, s_out, cnt hold; done = 0.
REQ-022 Counter: each shift or rotate with cnt < WIDTH increments cnt by 1; at cnt = WIDTH cnt saturates (no wrap to 0).
REQ-023 done = 1 for exactly the one cycle following the edge on which cnt transitions WIDTH-1 -> WIDTH; 0 otherwise, including while saturated.
REQ-024 Shifts/rotates with cnt saturated still update q and s_out normally.
REQ-025 Direction change mid-sequence is legal; cnt keeps counting regardless of dir.
REQ-026 Mixing shift and rotate between loads is legal; both count toward cnt.
REQ-027 Load while done is high clears done on the same edge; load takes effect immediately (no latency beyond one edge).
REQ-028 Unknown/X on modo or dir is a bench error; RTL need not define behaviour.

Reset
REQ-029 rst=1 on a rising edge: q = 0, s_out = 0, cnt = 0, done = 0, regardless of enb, modo or other inputs.
REQ-030 rst asserted mid-sequence (e.g. cnt = 2) aborts the sequence; no done pulse is produced for it.
REQ-031 Outputs are undefined before the first reset edge; the bench applies rst for at least 2 cycles at start.

Verification
REQ-032 Reset then load d=1011, enb=0 -> next edge q=1011, cnt=0, s_out=0, done=0.
REQ-033 After q=1011, four shift-left edges with s_in=0 -> s_out sequence 1,0,1,1; q ends 0000; cnt=4; done high only after 4th edge.
REQ-034 q=1001, rotate right x4 -> q sequence 1100,0110,0011,1001; s_out 1,0,0,1; fifth rotate -> q=1100, cnt stays 4, done=0.
REQ-035 q=0110, cnt=1, enb=1 for 3 edges with modo=00 -> q=0110, cnt=1, done=0 throughout; hold (modo=11) likewise unchanged.
REQ-036 q=1111, shift right s_in=0 twice (cnt=2), then rst=1 with enb=1, modo=00 -> q=0000, cnt=0, s_out=0, no done pulse.
REQ-037 Shift left x3 then shift right x1 from q=1000, s_in=1 -> q=0001,0011,0111 then 1011; done pulses after 4th edge.
